muldiv_issue_ctrl: RTL and testbench

//   Upstream issue/hazard controller for the HI/LO multiply-divide unit.

---
 rtl/muldiv_issue_ctrl.sv | 105 ++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue_ctrl.sv
// rtl/muldiv_issue_ctrl.sv - HI/LO multiply-divide issue strobes, latency tracking and D-stage stall; optional lockstep check via MULDIV_CHECK_EN
module muldiv_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       D_UseHILO,
    input  logic [2:0] E_MulOp,
    input  logic [1:0] E_MTHILO,
    input  logic       E_flush,
    input  logic       busy,
    output logic [2:0] MulOp_out,
    output logic [1:0] MTHILO_out,
    output logic       Stall,
    output logic       InFlight,
    output logic       CheckErr
);

    if (MUL_LAT < 1 || MUL_LAT > 15 || DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_lat
        $error("muldiv_issue_ctrl: MUL_LAT/DIV_LAT must be in 1..15");
    end

    localparam logic [3:0] MUL_REM = 4'(MUL_LAT);
    localparam logic [3:0] DIV_REM = 4'(DIV_LAT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       rem_zero;
    logic       issue_op;
    logic       issue_mv;

    // Qualifying with reset keeps the issue strobes and Stall idle while reset is held.
    assign rem_zero = (rem_q == 4'd0);
    assign issue_op = reset & ~E_flush & ~E_MulOp[2]  & rem_zero;
    assign issue_mv = reset & ~E_flush & ~E_MTHILO[1] & rem_zero;

    assign MulOp_out  = issue_op ? E_MulOp  : 3'b111;
    assign MTHILO_out = issue_mv ? E_MTHILO : 2'b11;
    assign Stall      = D_UseHILO & (issue_op | ~rem_zero);
    assign InFlight   = ~rem_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Ops reaching E while RUN are dropped: rem only reloads from IDLE.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (issue_op) begin
                    state_d = RUN;
                    rem_d   = E_MulOp[1] ? DIV_REM : MUL_REM;
                end
            end
            RUN: begin
                if (!rem_zero) begin
                    rem_d = rem_q - 4'd1;
                end
                if (rem_q <= 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = 4'd0;
            end
        endcase
    end

`ifdef MULDIV_CHECK_EN
    logic check_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            check_err_q <= 1'b0;
        end else if (busy != InFlight) begin
            check_err_q <= 1'b1;
`ifndef SYNTHESIS
            $display("muldiv_issue_ctrl: busy=%0b InFlight=%0b disagree at %0t", busy, InFlight, $time);
`endif
        end
    end

    assign CheckErr = check_err_q;
`else
    logic unused_busy;
    assign unused_busy = busy;
    assign CheckErr    = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb/tb_muldiv_issue_ctrl.sv - directed self-checking bench for muldiv_issue_ctrl
module tb_muldiv_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       D_UseHILO;
    logic [2:0] E_MulOp;
    logic [1:0] E_MTHILO;
    logic       E_flush;
    logic       busy;
    logic [2:0] MulOp_out;
    logic [1:0] MTHILO_out;
    logic       Stall;
    logic       InFlight;
    logic       CheckErr;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .D_UseHILO  (D_UseHILO),
        .E_MulOp    (E_MulOp),
        .E_MTHILO   (E_MTHILO),
        .E_flush    (E_flush),
        .busy       (busy),
        .MulOp_out  (MulOp_out),
        .MTHILO_out (MTHILO_out),
        .Stall      (Stall),
        .InFlight   (InFlight),
        .CheckErr   (CheckErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        D_UseHILO = 1'b0;
        E_MulOp   = 3'b111;
        E_MTHILO  = 2'b11;
        E_flush   = 1'b0;
        busy      = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        // Outputs must stay idle under reset even with a valid op presented.
        #1;
        D_UseHILO = 1'b1;
        E_MulOp   = 3'b001;
        E_MTHILO  = 2'b01;
        @(negedge clk);
        check("rst_mulop",  8'(MulOp_out),  8'h7);
        check("rst_mthilo", 8'(MTHILO_out), 8'h3);
        check("rst_stall",  8'(Stall),      8'h0);
        check("rst_infl",   8'(InFlight),   8'h0);
        check("rst_chk",    8'(CheckErr),   8'h0);
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        next_cycle();

        // Test 1: mult with D-stage HI/LO user; a stray div at cyc2 must be dropped.
        D_UseHILO = 1'b1;
        E_MulOp   = 3'b001;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("t1_mulop_c%0d", c), 8'(MulOp_out), (c == 0 || c == 3 && 0) ? 8'h1 : 8'h7);
            check($sformatf("t1_stall_c%0d", c), 8'(Stall),     (c <= 5) ? 8'h1 : 8'h0);
            check($sformatf("t1_infl_c%0d", c),  8'(InFlight),  (c >= 1 && c <= 5) ? 8'h1 : 8'h0);
            check($sformatf("t1_chk_c%0d", c),   8'(CheckErr),  8'h0);
            next_cycle();
            E_MulOp = (c + 1 == 2) ? 3'b011 : 3'b111;
            busy    = (c + 1 >= 1 && c + 1 <= 5);
        end
        idle_inputs();
        next_cycle();

        // Test 2: div latency, no D-stage user.
        E_MulOp = 3'b011;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("t2_mulop_c%0d", c), 8'(MulOp_out), (c == 0) ? 8'h3 : 8'h7);
            check($sformatf("t2_infl_c%0d", c),  8'(InFlight),  (c >= 1 && c <= 10) ? 8'h1 : 8'h0);
            check($sformatf("t2_stall_c%0d", c), 8'(Stall),     8'h0);
            check($sformatf("t2_chk_c%0d", c),   8'(CheckErr),  8'h0);
            next_cycle();
            E_MulOp = 3'b111;
            busy    = (c + 1 >= 1 && c + 1 <= 10);
        end
        idle_inputs();

        // Test 3: mthi alone is zero latency.
        D_UseHILO = 1'b1;
        E_MTHILO  = 2'b01;
        @(negedge clk);
        check("t3_mthilo_c0", 8'(MTHILO_out), 8'h1);
        check("t3_mulop_c0",  8'(MulOp_out),  8'h7);
        check("t3_stall_c0",  8'(Stall),      8'h0);
        next_cycle();
        E_MTHILO = 2'b11;
        @(negedge clk);
        check("t3_mthilo_c1", 8'(MTHILO_out), 8'h3);
        check("t3_infl_c1",   8'(InFlight),   8'h0);
        check("t3_stall_c1",  8'(Stall),      8'h0);
        next_cycle();

        // Test 4: flushed multu with a concurrent move suppresses everything.
        E_MulOp  = 3'b000;
        E_MTHILO = 2'b00;
        E_flush  = 1'b1;
        @(negedge clk);
        check("t4_mulop_c0",  8'(MulOp_out),  8'h7);
        check("t4_mthilo_c0", 8'(MTHILO_out), 8'h3);
        check("t4_stall_c0",  8'(Stall),      8'h0);
        next_cycle();
        idle_inputs();
        D_UseHILO = 1'b1;
        @(negedge clk);
        check("t4_infl_c1",  8'(InFlight), 8'h0);
        check("t4_stall_c1", 8'(Stall),    8'h0);
        next_cycle();

        // Test 5: reset at cyc3 of a divu, then a fresh mult with a same-cycle mtlo.
        E_MulOp = 3'b010;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            E_MulOp = 3'b111;
            busy    = 1'b1;
        end
        @(negedge clk);
        check("t5_stall_pre", 8'(Stall),    8'h1);
        check("t5_infl_pre",  8'(InFlight), 8'h1);
        #1;
        reset = 1'b0;
        busy  = 1'b0;
        #1;
        check("t5_stall_rst", 8'(Stall),    8'h0);
        check("t5_infl_rst",  8'(InFlight), 8'h0);
        next_cycle();
        reset    = 1'b1;
        E_MulOp  = 3'b001;
        E_MTHILO = 2'b00;
        @(negedge clk);
        check("t5_mulop",  8'(MulOp_out),  8'h1);
        check("t5_mthilo", 8'(MTHILO_out), 8'h0);
        check("t5_stall",  8'(Stall),      8'h1);
        next_cycle();
        E_MulOp  = 3'b111;
        E_MTHILO = 2'b11;
        busy     = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("t5_infl_c%0d", c), 8'(InFlight), (c <= 5) ? 8'h1 : 8'h0);
            next_cycle();
            busy = (c + 1 <= 5);
        end
        idle_inputs();

`ifdef MULDIV_CHECK_EN
        // Test 6: busy held low during RUN trips the sticky error.
        E_MulOp = 3'b001;
        next_cycle();
        E_MulOp = 3'b111;
        busy    = 1'b0;
        next_cycle();
        for (int c = 2; c < 9; c++) begin
            @(negedge clk);
            check($sformatf("t6_chk_c%0d", c), 8'(CheckErr), 8'h1);
            next_cycle();
        end
        reset = 1'b0;
        #1;
        check("t6_chk_rst", 8'(CheckErr), 8'h0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        check("t6_chk_after", 8'(CheckErr), 8'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
